// File: rtl/mux_logic_unit.sv
// Bitwise logic unit built from 2:1 mux primitives, with a serially loaded 4-entry truth table.
// Results are registered behind a valid/ready handshake; table loading stalls new operands.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no table load in progress, operands may be accepted
// ST_SHIFT | collecting table bits 1..3, or committing (done_q set)
module mux_logic_unit #(
    parameter int         WIDTH    = 8,
    parameter logic [3:0] LUT_INIT = 4'b0110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0]       stage_q, stage_d;
    logic [3:0]       lut_q, lut_d;
    logic             done_q, done_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             fire;

    function automatic logic mux2(input logic s, input logic in1, input logic in0);
        return s ? in1 : in0;
    endfunction

    logic [WIDTH-1:0] r_and, r_or, r_not, r_xor, r_xnor, r_nand, r_nor, r_lut;
    logic [WIDTH-1:0] lut_lo, lut_hi;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign r_not[i]  = mux2(b[i], 1'b0, 1'b1);
        assign r_and[i]  = mux2(a[i], b[i], 1'b0);
        assign r_or[i]   = mux2(a[i], 1'b1, b[i]);
        assign r_xor[i]  = mux2(a[i], r_not[i], b[i]);
        assign r_xnor[i] = mux2(a[i], b[i], r_not[i]);
        assign r_nand[i] = mux2(a[i], r_not[i], 1'b1);
        assign r_nor[i]  = mux2(a[i], 1'b0, r_not[i]);
        // 4:1 table lookup: b selects within each half, a picks the half
        assign lut_lo[i] = mux2(b[i], lut_q[1], lut_q[0]);
        assign lut_hi[i] = mux2(b[i], lut_q[3], lut_q[2]);
        assign r_lut[i]  = mux2(a[i], lut_hi[i], lut_lo[i]);
    end

    assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (fire) begin
            out_valid_d = 1'b1;
            case (op)
                3'd0:    y_d = r_and;
                3'd1:    y_d = r_or;
                3'd2:    y_d = r_not;
                3'd3:    y_d = r_xor;
                3'd4:    y_d = r_xnor;
                3'd5:    y_d = r_nand;
                3'd6:    y_d = r_nor;
                default: y_d = r_lut;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        lut_d   = lut_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 2'd1;
                    stage_d = {stage_q[2:0], cfg_bit};
                end
            end
            ST_SHIFT: begin
                // commit cycle: table already live, any cfg_valid here is dropped
                if (done_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                    stage_d = 4'd0;
                end else if (cfg_valid) begin
                    stage_d = {stage_q[2:0], cfg_bit};
                    if (cnt_q == 2'd3) begin
                        lut_d  = {stage_q[2:0], cfg_bit};
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            stage_q     <= 4'd0;
            lut_q       <= LUT_INIT;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            lut_q       <= lut_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign cfg_busy  = (state_q == ST_SHIFT);
    assign cfg_done  = done_q;

endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed and randomized bench for mux_logic_unit against a bitwise reference model.
module tb_mux_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         cfg_valid;
    logic         cfg_bit;
    logic         cfg_busy;
    logic         cfg_done;

    int checks   = 0;
    int failures = 0;

    mux_logic_unit #(.WIDTH(W), .LUT_INIT(4'b0110)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [2:0] rop, input logic [3:0] rlut);
        logic [W-1:0] r;
        case (rop)
            3'd0: r = ra & rb;
            3'd1: r = ra | rb;
            3'd2: r = ~rb;
            3'd3: r = ra ^ rb;
            3'd4: r = ~(ra ^ rb);
            3'd5: r = ~(ra & rb);
            3'd6: r = ~(ra | rb);
            default: for (int i = 0; i < W; i++) r[i] = rlut[{ra[i], rb[i]}];
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_y [7];
    logic [3:0]   m_lut;
    logic         m_ov;
    logic [W-1:0] m_y;
    logic         fire;
    int           busy_cnt, done_cnt;
    logic [3:0]   bits;

    initial begin
        exp_y[0] = 8'hC0; exp_y[1] = 8'hFC; exp_y[2] = 8'h33; exp_y[3] = 8'h3C;
        exp_y[4] = 8'hC3; exp_y[5] = 8'h3F; exp_y[6] = 8'h03;
        rst_n = 1'b0; in_valid = 1'b0; a = 8'hF0; b = 8'hCC; op = 3'd0;
        out_ready = 1'b1; cfg_valid = 1'b0; cfg_bit = 1'b0;

        // reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_cfg_done", cfg_done, 0);
        rst_n = 1'b1;
        #1 check("rel_in_ready", in_ready, 1);

        // each fixed op
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; op = 3'(k);
            tick();
            check($sformatf("op%0d_valid", k), out_valid, 1);
            check($sformatf("op%0d_y", k), y, exp_y[k]);
        end
        op = 3'd7;
        tick();
        check("lut_reset_y", y, 8'h3C);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // load table 1,0,0,0
        bits = 4'b1000; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cfg_valid = (k < 4);
            cfg_bit   = (k < 4) ? bits[3-k] : 1'b0;
            tick();
            busy_cnt += int'(cfg_busy);
            done_cnt += int'(cfg_done);
        end
        cfg_valid = 1'b0;
        check("cfg_busy_cycles", busy_cnt, 4);
        check("cfg_done_pulses", done_cnt, 1);
        in_valid = 1'b1; op = 3'd7;
        tick();
        check("lut_new_y", y, 8'hC0);
        in_valid = 1'b0;
        tick();

        // backpressure, then release
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0;
        tick();
        check("bp_first_y", y, 8'hC0);
        op = 3'd1;
        #1 check("bp_in_ready", in_ready, 0);
        tick(); tick();
        check("bp_hold_y", y, 8'hC0);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_or_y", y, 8'hFC);
        in_valid = 1'b0;
        tick();
        check("drain2_valid", out_valid, 0);
        check("drain2_y", y, 8'hFC);

        // reset during a partial load
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick(); tick();
        cfg_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; done_cnt = 0;
        in_valid = 1'b1; op = 3'd7;
        tick();
        done_cnt += int'(cfg_done);
        check("midrst_y", y, 8'h3C);
        check("midrst_busy", cfg_busy, 0);
        in_valid = 1'b0;
        tick();
        done_cnt += int'(cfg_done);
        check("midrst_no_done", done_cnt, 0);

        // simultaneous load start and transfer
        cfg_valid = 1'b1; cfg_bit = 1'b1; in_valid = 1'b1; op = 3'd7;
        #1 check("sim_in_ready", in_ready, 1);
        tick();
        check("sim_old_lut_y", y, 8'h3C);
        check("sim_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            cfg_valid = (k < 3);
            cfg_bit   = 1'b0;
            #1 check($sformatf("sim_stall%0d", k), in_ready, 0);
            tick();
        end
        check("sim_hold_y", y, 8'h3C);
        cfg_valid = 1'b0;
        #1 check("sim_ready_after", in_ready, 1);
        tick();
        check("sim_new_lut_y", y, 8'hC0);
        in_valid = 1'b0;
        tick();
        m_lut = 4'b1000;

        // full-throughput stream
        busy_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
            m_y = ref_fn(a, b, op, m_lut);
            tick();
            if (out_valid === 1'b1 && y === m_y) busy_cnt++;
            check($sformatf("stream%0d_y", k), y, m_y);
        end
        check("stream_count", busy_cnt, 16);
        in_valid = 1'b0;
        tick();

        // random handshake against model
        m_ov = 1'b0;
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
            #1;
            check("rnd_in_ready", in_ready, (!m_ov || out_ready));
            fire = in_valid && (!m_ov || out_ready);
            if (fire) begin
                m_y  = ref_fn(a, b, op, m_lut);
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            tick();
            check("rnd_valid", out_valid, m_ov);
            check("rnd_y", y, m_y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
